// File: rtl/bomb_game_pkg.sv
// Shared definitions for the bomb-defuse game sequencer: state encodings,
// BCD digit constants and default build parameters.
package bomb_game_pkg;

  localparam int BCD_W   = 4;
  localparam int BCD_MAX = 9;

  localparam int DEF_CODE_LEN         = 4;
  localparam int DEF_MAX_STRIKES      = 3;
  localparam int DEF_CFG_PULSE_CYCLES = 2;
  localparam int DEF_LOCKOUT_CYCLES   = 100;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CONFIG   = 3'd1,
    ST_RUN      = 3'd2,
    ST_CHECK    = 3'd3,
    ST_DEFUSED  = 3'd4,
    ST_EXPLODED = 3'd5
  } state_e;

  function automatic logic is_bcd(input logic [BCD_W-1:0] d);
    return (d <= BCD_W'(BCD_MAX));
  endfunction

endpackage

// File: rtl/code_entry_buf.sv
// Defuse-code entry buffer: stores digits by position, tracks how many have
// been entered and compares the completed entry against the latched code.
module code_entry_buf
  import bomb_game_pkg::*;
#(
  parameter int CODE_LEN = DEF_CODE_LEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      push,
  input  logic [BCD_W-1:0]          digit,
  input  logic [BCD_W*CODE_LEN-1:0] code,
  output logic [3:0]                entry_cnt,
  output logic                      full,
  output logic                      match
);

  logic [BCD_W*CODE_LEN-1:0] ent_q, ent_d;
  logic [3:0]                cnt_q, cnt_d;

  assign full      = (cnt_q == 4'(CODE_LEN));
  assign match     = full && (ent_q == code);
  assign entry_cnt = cnt_q;

  // clr beats push so a same-cycle clear always discards the digit.
  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    if (clr) begin
      ent_d = '0;
      cnt_d = '0;
    end else if (push && !full) begin
      for (int i = 0; i < CODE_LEN; i++) begin
        if (cnt_q == 4'(i)) begin
          ent_d[i*BCD_W +: BCD_W] = digit;
        end
      end
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bomb_game_ctrl.sv
// Bomb-defuse game sequencer: arms the countdown timer, collects code digits,
// counts strikes and declares DEFUSED or EXPLODED.
// Build option: define BOMB_CTRL_LOCKOUT_EN for a post-strike digit lockout.
module bomb_game_ctrl
  import bomb_game_pkg::*;
#(
  parameter int CODE_LEN         = DEF_CODE_LEN,
  parameter int MAX_STRIKES      = DEF_MAX_STRIKES,
  parameter int CFG_PULSE_CYCLES = DEF_CFG_PULSE_CYCLES,
  parameter int LOCKOUT_CYCLES   = DEF_LOCKOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BCD_W*CODE_LEN-1:0] secret_code,
  input  logic [BCD_W-1:0]          digit_in,
  input  logic                      digit_valid,
  input  logic                      clear,
  input  logic                      timer_timeout,
  output logic                      timer_enable,
  output logic                      timer_reconfig_n,
  output logic [2:0]                state_o,
  output logic [3:0]                entry_cnt,
  output logic [2:0]                strikes,
  output logic                      defused,
  output logic                      exploded
);

  // Inputs are one-cycle strobes without back-pressure: start, digit_valid
  // and clear act in the cycle they are high or are dropped for good.
  localparam int CFG_W  = (CFG_PULSE_CYCLES < 1) ? 1 : $clog2(CFG_PULSE_CYCLES + 1);
  localparam int LOCK_W = (LOCKOUT_CYCLES < 1) ? 1 : $clog2(LOCKOUT_CYCLES + 1);

  state_e                    state_q, state_d;
  logic [CFG_W-1:0]          cfg_cnt_q, cfg_cnt_d;
  logic [2:0]                strikes_q, strikes_d;
  logic [BCD_W*CODE_LEN-1:0] code_q, code_d;
  logic                      timer_enable_q, timer_enable_d;
  logic                      timer_reconfig_n_q, timer_reconfig_n_d;

  logic             start_ok, run_live, push, user_clr, retry, buf_clr;
  logic             full, match, last_strike;
  logic [2:0]       strike_next;
  logic [LOCK_W-1:0] lock_cnt;

  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DEFUSED) ||
                              (state_q == ST_EXPLODED));
  // Timeout pre-empts any digit or clear arriving in the same RUN cycle.
  assign run_live    = (state_q == ST_RUN) && !timer_timeout && (lock_cnt == '0);
  assign push        = run_live && digit_valid && !clear && is_bcd(digit_in);
  assign user_clr    = run_live && clear;
  assign strike_next = strikes_q + 3'd1;
  assign last_strike = (strike_next == 3'(MAX_STRIKES));
  assign retry       = (state_q == ST_CHECK) && !timer_timeout && !match && !last_strike;
  assign buf_clr     = start_ok || retry || user_clr;

  code_entry_buf #(
    .CODE_LEN (CODE_LEN)
  ) u_entry (
    .clk       (clk),
    .rst       (rst),
    .clr       (buf_clr),
    .push      (push),
    .digit     (digit_in),
    .code      (code_q),
    .entry_cnt (entry_cnt),
    .full      (full),
    .match     (match)
  );

`ifdef BOMB_CTRL_LOCKOUT_EN
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (state_q == ST_CONFIG) begin
      lock_cnt_d = '0;
    end else if (retry) begin
      lock_cnt_d = LOCK_W'(LOCKOUT_CYCLES);
    end else if (lock_cnt_q != '0) begin
      lock_cnt_d = lock_cnt_q - LOCK_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt_q <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign lock_cnt = lock_cnt_q;
`else
  assign lock_cnt = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= ST_IDLE;
      cfg_cnt_q          <= '0;
      strikes_q          <= '0;
      code_q             <= '0;
      timer_enable_q     <= 1'b0;
      timer_reconfig_n_q <= 1'b1;
    end else begin
      state_q            <= state_d;
      cfg_cnt_q          <= cfg_cnt_d;
      strikes_q          <= strikes_d;
      code_q             <= code_d;
      timer_enable_q     <= timer_enable_d;
      timer_reconfig_n_q <= timer_reconfig_n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cfg_cnt_d = cfg_cnt_q;
    strikes_d = strikes_q;
    code_d    = code_q;
    case (state_q)
      ST_IDLE, ST_DEFUSED, ST_EXPLODED: begin
        if (start_ok) begin
          state_d   = ST_CONFIG;
          cfg_cnt_d = '0;
          strikes_d = '0;
          code_d    = secret_code;
        end
      end
      // Reload pulse low for CFG_PULSE_CYCLES, then one high cycle before RUN.
      ST_CONFIG: begin
        if (cfg_cnt_q == CFG_W'(CFG_PULSE_CYCLES)) begin
          state_d = ST_RUN;
        end else begin
          cfg_cnt_d = cfg_cnt_q + CFG_W'(1);
        end
      end
      ST_RUN: begin
        if (timer_timeout) begin
          state_d = ST_EXPLODED;
        end else if (push && (entry_cnt == 4'(CODE_LEN - 1))) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (timer_timeout) begin
          state_d = ST_EXPLODED;
        end else if (full && match) begin
          state_d = ST_DEFUSED;
        end else begin
          strikes_d = strike_next;
          state_d   = last_strike ? ST_EXPLODED : ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Timer controls are registered from the next state so the strobes are glitch-free.
  always_comb begin
    timer_enable_d     = (state_d == ST_RUN) || (state_d == ST_CHECK);
    timer_reconfig_n_d = !((state_d == ST_CONFIG) && (cfg_cnt_d < CFG_W'(CFG_PULSE_CYCLES)));
  end

  assign timer_enable     = timer_enable_q;
  assign timer_reconfig_n = timer_reconfig_n_q;
  assign state_o          = state_q;
  assign strikes          = strikes_q;
  assign defused          = (state_q == ST_DEFUSED);
  assign exploded         = (state_q == ST_EXPLODED);

endmodule

// File: tb/tb_bomb_game_ctrl.sv
// Self-checking bench for bomb_game_ctrl: directed vector table, hand-written
// reset/lockout sequences and randomized traffic against a queue-based model.
module tb_bomb_game_ctrl;

  localparam int CODE_LEN = 4;
  localparam int MAX_STR  = 3;
  localparam int CFG      = 2;
  localparam int LOCK     = 10;
`ifdef BOMB_CTRL_LOCKOUT_EN
  localparam int GAP = LOCK;
`else
  localparam int GAP = 0;
`endif

  localparam int S_IDLE = 0, S_CONFIG = 1, S_RUN = 2, S_CHECK = 3, S_DEF = 4, S_EXP = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] secret_code = '0;
  logic [3:0]  digit_in = '0;
  logic        digit_valid = 1'b0;
  logic        clear = 1'b0;
  logic        timer_timeout = 1'b0;
  logic        timer_enable, timer_reconfig_n, defused, exploded;
  logic [2:0]  state_o, strikes;
  logic [3:0]  entry_cnt;

  int checks = 0;
  int failures = 0;

  bomb_game_ctrl #(
    .CODE_LEN(CODE_LEN), .MAX_STRIKES(MAX_STR), .CFG_PULSE_CYCLES(CFG), .LOCKOUT_CYCLES(LOCK)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .secret_code(secret_code),
    .digit_in(digit_in), .digit_valid(digit_valid), .clear(clear),
    .timer_timeout(timer_timeout), .timer_enable(timer_enable),
    .timer_reconfig_n(timer_reconfig_n), .state_o(state_o), .entry_cnt(entry_cnt),
    .strikes(strikes), .defused(defused), .exploded(exploded)
  );

  always #5 clk = ~clk;

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int es, input int ec, input int estr,
                         input int een, input int ern);
    chk({tag, ".state"},    32'(state_o),          es);
    chk({tag, ".entry"},    32'(entry_cnt),        ec);
    chk({tag, ".strikes"},  32'(strikes),          estr);
    chk({tag, ".en"},       32'(timer_enable),     een);
    chk({tag, ".rcfg_n"},   32'(timer_reconfig_n), ern);
    chk({tag, ".defused"},  32'(defused),          32'(es == S_DEF));
    chk({tag, ".exploded"}, 32'(exploded),         32'(es == S_EXP));
  endtask

  task automatic arm();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (CFG + 1) tick();
  endtask

  task automatic enter(input logic [3:0] d);
    digit_valid = 1'b1;
    digit_in    = d;
    tick();
    digit_valid = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       st, dv;
    logic [3:0] d;
    logic       cl, to;
    int         es, ec, estr, een, ern;
  } vec_t;
  vec_t vq[$];

  function automatic void add(input logic st, input logic dv, input logic [3:0] d,
                              input logic cl, input logic to, input int es, input int ec,
                              input int estr, input int een, input int ern);
    vec_t v;
    v.st = st; v.dv = dv; v.d = d; v.cl = cl; v.to = to;
    v.es = es; v.ec = ec; v.estr = estr; v.een = een; v.ern = ern;
    vq.push_back(v);
  endfunction

  function automatic void add_arm();
    add(1, 0, 0, 0, 0, S_CONFIG, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, S_CONFIG, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, S_CONFIG, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, S_RUN,    0, 0, 1, 1);
  endfunction

  // ---------------- reference model ----------------
  int m_mode, m_cfg_age, m_strikes, m_lock;
  int m_code[CODE_LEN];
  int m_digits[$];

  function automatic void m_reset();
    m_mode = S_IDLE; m_cfg_age = 0; m_strikes = 0; m_lock = 0;
    m_digits.delete();
    foreach (m_code[i]) m_code[i] = 0;
  endfunction

  function automatic void m_step(input logic st, input logic dv, input logic [3:0] d,
                                 input logic cl, input logic to);
    int  lock_pre;
    bit  ok;
    lock_pre = m_lock;
    if (m_lock > 0) m_lock--;
    case (m_mode)
      S_IDLE, S_DEF, S_EXP:
        if (st) begin
          m_mode = S_CONFIG; m_cfg_age = 0; m_strikes = 0; m_lock = 0;
          m_digits.delete();
          foreach (m_code[i]) m_code[i] = int'(secret_code[i*4 +: 4]);
        end
      S_CONFIG:
        if (m_cfg_age == CFG) m_mode = S_RUN;
        else m_cfg_age++;
      S_RUN:
        if (to) m_mode = S_EXP;
        else if (lock_pre == 0) begin
          if (cl) m_digits.delete();
          else if (dv && d <= 4'd9) begin
            m_digits.push_back(int'(d));
            if (m_digits.size() == CODE_LEN) m_mode = S_CHECK;
          end
        end
      S_CHECK:
        if (to) m_mode = S_EXP;
        else begin
          ok = 1'b1;
          foreach (m_code[i]) if (m_digits[i] != m_code[i]) ok = 1'b0;
          if (ok) m_mode = S_DEF;
          else begin
            m_strikes++;
            if (m_strikes == MAX_STR) m_mode = S_EXP;
            else begin
              m_mode = S_RUN;
              m_digits.delete();
              m_lock = GAP;
            end
          end
        end
      default: m_mode = S_IDLE;
    endcase
  endfunction

  task automatic chk_model(input string tag);
    chk_all(tag, m_mode, m_digits.size(), m_strikes,
            int'(m_mode == S_RUN || m_mode == S_CHECK),
            int'(!(m_mode == S_CONFIG && m_cfg_age < CFG)));
  endtask

  // ---------------- test ----------------
  initial begin
    // Directed table: arm, entry corner cases, defuse, three strikes, timeout.
    add_arm();
    vq[1].to = 1'b1;                           // timeout ignored in CONFIG
    add(0, 1, 1,     0, 0, S_RUN, 1, 0, 1, 1);
    add(0, 1, 4'hA,  0, 0, S_RUN, 1, 0, 1, 1); // non-BCD digit ignored
    add(0, 1, 2,     0, 0, S_RUN, 2, 0, 1, 1);
    add(0, 1, 9,     1, 0, S_RUN, 0, 0, 1, 1); // clear beats digit
    add(1, 1, 1,     0, 0, S_RUN, 1, 0, 1, 1); // start ignored in RUN
    add(0, 1, 2,     0, 0, S_RUN, 2, 0, 1, 1);
    add(0, 1, 3,     0, 0, S_RUN, 3, 0, 1, 1);
    add(0, 1, 4,     0, 0, S_CHECK, 4, 0, 1, 1);
    add(0, 0, 0,     0, 0, S_DEF, 4, 0, 0, 1);
    add(0, 1, 5,     1, 1, S_DEF, 4, 0, 0, 1);
    add_arm();
    for (int k = 1; k <= MAX_STR; k++) begin
      add(0, 1, 1, 0, 0, S_RUN,   1, k - 1, 1, 1);
      add(0, 1, 2, 0, 0, S_RUN,   2, k - 1, 1, 1);
      add(0, 1, 3, 0, 0, S_RUN,   3, k - 1, 1, 1);
      add(0, 1, 5, 0, 0, S_CHECK, 4, k - 1, 1, 1);
      if (k < MAX_STR) begin
        add(0, 0, 0, 0, 0, S_RUN, 0, k, 1, 1);
        for (int g = 0; g < GAP; g++) add(0, 0, 0, 0, 0, S_RUN, 0, k, 1, 1);
      end else begin
        add(0, 0, 0, 0, 0, S_EXP, 4, k, 0, 1);
      end
    end
    add_arm();
    add(0, 1, 1, 0, 0, S_RUN, 1, 0, 1, 1);
    add(0, 1, 2, 0, 0, S_RUN, 2, 0, 1, 1);
    add(0, 1, 3, 0, 1, S_EXP, 2, 0, 0, 1); // timeout beats digit

    secret_code = 16'h4321;
    #2 rst = 1'b1;
    #1 chk_all("reset", S_IDLE, 0, 0, 0, 1);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk_all("post_reset", S_IDLE, 0, 0, 0, 1);

    foreach (vq[i]) begin
      start = vq[i].st; digit_valid = vq[i].dv; digit_in = vq[i].d;
      clear = vq[i].cl; timer_timeout = vq[i].to;
      tick();
      chk_all($sformatf("vec%0d", i), vq[i].es, vq[i].ec, vq[i].estr, vq[i].een, vq[i].ern);
    end
    start = 1'b0; digit_valid = 1'b0; clear = 1'b0; timer_timeout = 1'b0;

    // Asynchronous reset in the middle of RUN, then re-arm.
    arm();
    enter(4'd7);
    chk_all("mid_run", S_RUN, 1, 0, 1, 1);
    rst = 1'b1;
    #1 chk_all("mid_rst", S_IDLE, 0, 0, 0, 1);
    rst = 1'b0;
    arm();
    chk_all("rearm", S_RUN, 0, 0, 1, 1);

    // Digit on the first RUN cycle after a wrong attempt.
    for (int i = 0; i < CODE_LEN; i++) enter(4'd9);
    tick();
    chk_all("retry", S_RUN, 0, 1, 1, 1);
`ifdef BOMB_CTRL_LOCKOUT_EN
    for (int i = 0; i < LOCK; i++) begin
      digit_valid = 1'b1; digit_in = 4'd5; clear = 1'b0;
      tick();
      chk($sformatf("lockout%0d.entry", i), 32'(entry_cnt), 0);
    end
`endif
    enter(4'd5);
    chk_all("after_retry", S_RUN, 1, 1, 1, 1);

    // Randomized traffic against the reference model.
    rst = 1'b1;
    #1 m_reset();
    chk_model("rand_init");
    rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < CODE_LEN; k++) secret_code[k*4 +: 4] = 4'($urandom_range(0, 9));
      digit_valid = 1'($urandom_range(0, 1));
      if (m_mode == S_RUN && m_digits.size() < CODE_LEN && $urandom_range(0, 9) < 7)
        digit_in = 4'(m_code[m_digits.size()]);
      else
        digit_in = 4'($urandom_range(0, 15));
      clear = ($urandom_range(0, 24) == 0);
      timer_timeout = ($urandom_range(0, 59) == 0);
      tick();
      m_step(start, digit_valid, digit_in, clear, timer_timeout);
      chk_model($sformatf("rand%0d", n));
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        #1 m_reset();
        chk_model($sformatf("rand_rst%0d", n));
        rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
